// File: rtl/led_sweep_if.sv
// AXI4-Lite bus bundle between the LED sweep master and its LED register slave.
// All five channels are present. The read channel is part of the bundle but the
// master never uses it.
//   master modport: drives AW/W valid+payload, BREADY, AR/R master side
//   slave  modport: drives AWREADY/WREADY, B response, AR/R slave side
interface led_sweep_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/led_sweep_master.sv
// LED sweep master: steps a lit "eye" of EYE_W LEDs across an LED_W wide
// register and writes each frame to SLAVE_ADDR over AXI4-Lite. The frames are
// spaced ms_delay milliseconds apart.
//   clk, resetn : clock, async active-low reset
//   button      : start/pause; each rising edge toggles running
//   mode        : 0 bounce, 1 rotate left, 2 rotate right, 3 hold
//   ms_delay    : inter-frame delay in ms
//   running     : sweep active
//   wr_err      : sticky, set by any non-OKAY write response
//   m_axi       : AXI4-Lite master (write only; read channel tied off)
module led_sweep_master #(
    parameter int          FREQ_HZ    = 100000000,
    parameter logic [31:0] SLAVE_ADDR = 32'h1000,
    parameter int          LED_W      = 16,
    parameter int          EYE_W      = 3,
    parameter int          MS_W       = 10
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            button,
    input  logic [1:0]      mode,
    input  logic [MS_W-1:0] ms_delay,
    output logic            running,
    output logic            wr_err,
    led_sweep_if.master     m_axi
);

    localparam logic [31:0]      CLOCKS_PER_MSEC = 32'(FREQ_HZ / 1000);
    localparam logic [LED_W-1:0] EYE_INIT        = LED_W'((33'd1 << EYE_W) - 33'd1);

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, RESP, WAIT, NEXT} state_t;

    state_t           state;
    logic [LED_W-1:0] pattern;
    logic             dir_left;
    logic [31:0]      delay;
    logic             init_wr;   // current write is the power-up clear
    logic             button_q;
    logic             awvalid, wvalid, bready;
    logic [31:0]      wdata;

    logic [LED_W-1:0] nxt_pat;
    logic             nxt_left;
    logic [31:0]      pat_ext;
    logic             aw_done, w_done;

    // Next frame. In bounce mode, an eye that touches an edge reverses
    // direction and moves in the same step, so the edge frame is shown once.
    always_comb begin
        nxt_pat  = pattern;
        nxt_left = dir_left;
        case (mode)
            2'd0: begin
                if (dir_left) begin
                    if (pattern[LED_W-1]) begin
                        nxt_left = 1'b0;
                        nxt_pat  = pattern >> 1;
                    end else begin
                        nxt_pat  = pattern << 1;
                    end
                end else begin
                    if (pattern[0]) begin
                        nxt_left = 1'b1;
                        nxt_pat  = pattern << 1;
                    end else begin
                        nxt_pat  = pattern >> 1;
                    end
                end
            end
            2'd1:    nxt_pat = {pattern[LED_W-2:0], pattern[LED_W-1]};
            2'd2:    nxt_pat = {pattern[0], pattern[LED_W-1:1]};
            default: nxt_pat = pattern;
        endcase
    end

    always_comb begin
        pat_ext              = '0;
        pat_ext[LED_W-1:0]   = pattern;
    end

    // Each channel is finished once its VALID has dropped, or it is handshaking now.
    assign aw_done = !awvalid || m_axi.awready;
    assign w_done  = !wvalid  || m_axi.wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= INIT;
            pattern  <= EYE_INIT;
            dir_left <= 1'b1;
            delay    <= '0;
            init_wr  <= 1'b0;
            button_q <= 1'b0;
            running  <= 1'b0;
            wr_err   <= 1'b0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            wdata    <= '0;
        end else begin
            button_q <= button;
            if (button && !button_q)
                running <= !running;

            case (state)
                INIT: begin
                    pattern  <= EYE_INIT;
                    dir_left <= 1'b1;
                    wdata    <= '0;
                    awvalid  <= 1'b1;
                    wvalid   <= 1'b1;
                    init_wr  <= 1'b1;
                    state    <= ISSUE;
                end
                IDLE: begin
                    if (running) begin
                        wdata   <= pat_ext;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        init_wr <= 1'b0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (awvalid && m_axi.awready) awvalid <= 1'b0;
                    if (wvalid && m_axi.wready)   wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi.bvalid) begin
                        bready <= 1'b0;
                        if (m_axi.bresp != 2'b00) wr_err <= 1'b1;
                        if (init_wr) begin
                            state <= IDLE;
                        end else begin
                            delay <= 32'(ms_delay) * CLOCKS_PER_MSEC;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Leave when the count reaches zero. This gives
                    // ms_delay*CLOCKS_PER_MSEC cycles in WAIT. A zero delay
                    // still takes one cycle.
                    if (delay <= 32'd1) begin
                        delay <= '0;
                        state <= NEXT;
                    end else begin
                        delay <= delay - 32'd1;
                    end
                end
                NEXT: begin
                    pattern  <= nxt_pat;
                    dir_left <= nxt_left;
                    state    <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

    assign m_axi.awaddr  = SLAVE_ADDR;
    assign m_axi.awvalid = awvalid;
    assign m_axi.wdata   = wdata;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wvalid;
    assign m_axi.bready  = bready;
    assign m_axi.araddr  = '0;
    assign m_axi.arvalid = 1'b0;
    assign m_axi.rready  = 1'b0;

    logic unused_rd;
    assign unused_rd = ^{m_axi.arready, m_axi.rvalid, m_axi.rdata, m_axi.rresp};

endmodule
